operand_fetch: RTL

- Downstream consumer of the 16x16 general-purpose register bank, which has a single combinational read port.
- Takes a two-source request from the control unit and reads both operands sequentially through that one port.
- Latches the operands and presents them to the ALU with a valid/ready handshake.
- Sits between the register bank's read port (addr_out/data_out) and the ALU operand inputs.

---
 rtl/operand_fetch_if.sv | 35 +++
 rtl/operand_fetch.sv | 85 ++++++++
 2 files changed

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: bundles the request, register-bank read port and ALU handshake
// signals of the operand fetch unit.
//   start/src_a/src_b : request from the control unit
//   busy              : fetch unit is not idle
//   rd_addr/rd_data   : register bank read port (combinational read)
//   op_a/op_b         : latched operands to the ALU
//   op_valid/op_ready : ALU handshake
// Modports:
//   master : the surroundings (control unit, register bank, ALU)
//   slave  : the operand fetch unit itself
interface operand_fetch_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              start;
   logic [ADDR_W-1:0] src_a;
   logic [ADDR_W-1:0] src_b;
   logic              busy;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              op_valid;
   logic              op_ready;

   modport master (
      output start, src_a, src_b, rd_data, op_ready,
      input  busy, rd_addr, op_a, op_b, op_valid
   );

   modport slave (
      input  start, src_a, src_b, rd_data, op_ready,
      output busy, rd_addr, op_a, op_b, op_valid
   );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: reads two source operands through the register bank's single
// combinational read port (A first, then B), latches them and offers them to
// the ALU with a valid/ready handshake.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : operand_fetch_if.slave (request, read port, ALU handshake)
// Optional build macro OPFETCH_SAME_SRC_EN: when both sources name the same
// register, one read fills both operands and FETCH_B is skipped.
module operand_fetch #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input logic           clk,
   input logic           rst,
   operand_fetch_if.slave bus
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] FETCH_A = 2'd1;
   localparam logic [1:0] FETCH_B = 2'd2;
   localparam logic [1:0] HOLD    = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] a_idx_q, b_idx_q;
   logic [DATA_W-1:0] op_a_q, op_b_q;
   logic              same_src;

`ifdef OPFETCH_SAME_SRC_EN
   assign same_src = (a_idx_q == b_idx_q);
`else
   assign same_src = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = FETCH_A;
         FETCH_A: state_d = same_src ? HOLD : FETCH_B;
         FETCH_B: state_d = HOLD;
         HOLD:    if (bus.op_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_idx_q <= '0;
         b_idx_q <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
      end else begin
         state_q <= state_d;
         // Requests are only taken in IDLE; a start while busy is dropped.
         if (state_q == IDLE && bus.start) begin
            a_idx_q <= bus.src_a;
            b_idx_q <= bus.src_b;
         end
         if (state_q == FETCH_A) begin
            op_a_q <= bus.rd_data;
            if (same_src) op_b_q <= bus.rd_data;
         end
         if (state_q == FETCH_B) begin
            op_b_q <= bus.rd_data;
         end
      end
   end

   // Read address depends on state only; zero outside the fetch cycles.
   always_comb begin
      bus.rd_addr = '0;
      case (state_q)
         FETCH_A: bus.rd_addr = a_idx_q;
         FETCH_B: bus.rd_addr = b_idx_q;
         default: bus.rd_addr = '0;
      endcase
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.op_valid = (state_q == HOLD);
   assign bus.op_a     = op_a_q;
   assign bus.op_b     = op_b_q;

endmodule
